// File: rtl/flow_ctrl_pkg.sv
// Shared definitions for the flow-control FSM: state codes, widths and reset-time thresholds.
package flow_ctrl_pkg;

  localparam int NQ_DEF       = 4;
  localparam int THR_W_DEF    = 3;
  localparam int STATE_W      = 3;
  localparam int IDLE_CYC_DEF = 4;

  localparam logic [THR_W_DEF-1:0] THR_LO_DEF = 3'd1;
  localparam logic [THR_W_DEF-1:0] THR_HI_DEF = 3'd6;

  typedef enum logic [STATE_W-1:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_e;

endpackage

// File: rtl/flow_ctrl_fsm_idle_timer.sv
// Counts consecutive all-empty cycles while enabled; expired flags the last cycle of the run.
module idle_timer #(
  parameter int IDLE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic all_empty,
  output logic expired
);

  localparam int CW = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(IDLE_CYC - 1);

  logic [CW-1:0] cnt_r;

  assign expired = en & all_empty & (cnt_r == LAST);

  // Run-length counter; any break in the run, expiry or leaving ACTIVE restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (!en || !all_empty || expired) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/flow_ctrl_fsm.sv
// Control FSM for the 4-queue FIFO/arbiter datapath: config, run/idle sequencing and
// sticky overflow error capture.
module flow_ctrl_fsm
  import flow_ctrl_pkg::*;
#(
  parameter int NQ       = NQ_DEF,
  parameter int THR_W    = THR_W_DEF,
  parameter int IDLE_CYC = IDLE_CYC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic [THR_W-1:0]   thr_lo_in,
  input  logic [THR_W-1:0]   thr_hi_in,
  input  logic [NQ-1:0]      fifo_empty,
  input  logic [NQ-1:0]      fifo_full,
  input  logic [NQ-1:0]      fifo_push,
  output logic [STATE_W-1:0] state,
  output logic [THR_W-1:0]   thr_lo,
  output logic [THR_W-1:0]   thr_hi,
  output logic               active,
  output logic               idle,
  output logic               error,
  output logic [NQ-1:0]      err_vec,
  output logic               cfg_bad
);

  state_e           state_r, state_nx;
  logic [THR_W-1:0] thr_lo_r, thr_lo_nx, thr_hi_r, thr_hi_nx;
  logic [NQ-1:0]    err_vec_r, err_vec_nx;
  logic             cfg_bad_r, cfg_bad_nx;
  logic [NQ-1:0]    ovf;
  logic             all_empty;
  logic             expired;

  assign ovf       = fifo_push & fifo_full;
  assign all_empty = &fifo_empty;

  idle_timer #(.IDLE_CYC(IDLE_CYC)) u_idle_timer (
    .clk       (clk),
    .reset     (reset),
    .en        (state_r == S_ACTIVE),
    .all_empty (all_empty),
    .expired   (expired)
  );

  // Next-state and next-register decode; overflow outranks init, which outranks emptiness.
  always_comb begin
    state_nx   = S_RESET;
    thr_lo_nx  = thr_lo_r;
    thr_hi_nx  = thr_hi_r;
    err_vec_nx = err_vec_r;
    cfg_bad_nx = cfg_bad_r;
    case (state_r)
      S_RESET: state_nx = S_INIT;
      S_INIT: begin
        if (thr_lo_in < thr_hi_in) begin
          thr_lo_nx = thr_lo_in;
          thr_hi_nx = thr_hi_in;
        end else begin
          cfg_bad_nx = 1'b1;
        end
        if (init) state_nx = S_INIT;
        else      state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (|ovf) begin
          state_nx   = S_ERROR;
          err_vec_nx = err_vec_r | ovf;
        end else if (init) begin
          state_nx = S_INIT;
        end else if (!all_empty) begin
          state_nx = S_ACTIVE;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (|ovf) begin
          state_nx   = S_ERROR;
          err_vec_nx = err_vec_r | ovf;
        end else if (init) begin
          state_nx = S_INIT;
        end else if (expired) begin
          state_nx = S_IDLE;
        end else begin
          state_nx = S_ACTIVE;
        end
      end
      S_ERROR: begin
        // Leaving ERROR wipes the captured overflow history for the next run.
        if (init) begin
          state_nx   = S_INIT;
          err_vec_nx = '0;
        end else begin
          state_nx   = S_ERROR;
          err_vec_nx = err_vec_r | ovf;
        end
      end
      default: state_nx = S_RESET;
    endcase
  end

  // State, threshold and sticky-flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_RESET;
      thr_lo_r  <= THR_W'(THR_LO_DEF);
      thr_hi_r  <= THR_W'(THR_HI_DEF);
      err_vec_r <= '0;
      cfg_bad_r <= 1'b0;
    end else begin
      state_r   <= state_nx;
      thr_lo_r  <= thr_lo_nx;
      thr_hi_r  <= thr_hi_nx;
      err_vec_r <= err_vec_nx;
      cfg_bad_r <= cfg_bad_nx;
    end
  end

  assign state   = state_r;
  assign thr_lo  = thr_lo_r;
  assign thr_hi  = thr_hi_r;
  assign err_vec = err_vec_r;
  assign cfg_bad = cfg_bad_r;
  assign active  = (state_r == S_ACTIVE);
  assign idle    = (state_r == S_IDLE);
  assign error   = (state_r == S_ERROR);

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// Directed plus randomized bench for flow_ctrl_fsm against a behavioural reference model.
module tb_flow_ctrl_fsm;

  localparam int IDLE_N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [2:0] thr_lo_in, thr_hi_in;
  logic [3:0] fifo_empty, fifo_full, fifo_push;
  logic [2:0] state;
  logic [2:0] thr_lo, thr_hi;
  logic       active, idle, error, cfg_bad;
  logic [3:0] err_vec;

  int tests = 0;
  int fails = 0;

  // reference model: phase number, thresholds, sticky flags, current empty run length
  int         m_state;
  logic [2:0] m_lo, m_hi;
  logic [3:0] m_err;
  logic       m_bad;
  int         m_run;

  flow_ctrl_fsm dut (
    .clk(clk), .reset(reset), .init(init),
    .thr_lo_in(thr_lo_in), .thr_hi_in(thr_hi_in),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_push(fifo_push),
    .state(state), .thr_lo(thr_lo), .thr_hi(thr_hi),
    .active(active), .idle(idle), .error(error),
    .err_vec(err_vec), .cfg_bad(cfg_bad)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("state",   32'(state),   32'(m_state));
    check("thr_lo",  32'(thr_lo),  32'(m_lo));
    check("thr_hi",  32'(thr_hi),  32'(m_hi));
    check("active",  32'(active),  32'(m_state == 3));
    check("idle",    32'(idle),    32'(m_state == 2));
    check("error",   32'(error),   32'(m_state == 4));
    check("err_vec", 32'(err_vec), 32'(m_err));
    check("cfg_bad", 32'(cfg_bad), 32'(m_bad));
  endtask

  task automatic model_reset();
    m_state = 0; m_lo = 3'd1; m_hi = 3'd6; m_err = 4'd0; m_bad = 1'b0; m_run = 0;
  endtask

  // One clock of the rules, computed from the current inputs.
  task automatic model_step();
    logic [3:0] ovf;
    int ns;
    ovf = fifo_push & fifo_full;
    ns  = m_state;
    if (m_state == 0) begin
      ns = 1;
    end else if (m_state == 1) begin
      if (thr_lo_in < thr_hi_in) begin m_lo = thr_lo_in; m_hi = thr_hi_in; end
      else m_bad = 1'b1;
      ns = init ? 1 : 2;
    end else if (m_state == 2 || m_state == 3) begin
      if (fifo_empty == 4'hf) m_run = m_run + 1; else m_run = 0;
      if (ovf != 4'd0) begin ns = 4; m_err = m_err | ovf; end
      else if (init) ns = 1;
      else if (m_state == 2 && fifo_empty != 4'hf) ns = 3;
      else if (m_state == 3 && m_run >= IDLE_N) ns = 2;
    end else begin
      if (init) begin ns = 1; m_err = 4'd0; end
      else m_err = m_err | ovf;
    end
    if (ns != 3) m_run = 0;
    m_state = ns;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #2;
    check_all();
    reset = 1'b0;
  endtask

  task automatic set_in(input logic i, input logic [3:0] e, input logic [3:0] f, input logic [3:0] p);
    init = i; fifo_empty = e; fifo_full = f; fifo_push = p;
  endtask

  initial begin
    reset = 1'b0;
    init = 1'b1; thr_lo_in = 3'd2; thr_hi_in = 3'd5;
    fifo_empty = 4'hf; fifo_full = 4'h0; fifo_push = 4'h0;
    #3;
    do_reset();
    // release -> INIT, then config 2/5 accepted, 3/3 rejected
    cycle();
    cycle();
    check("cfg_lo_2", 32'(thr_lo), 32'd2);
    thr_lo_in = 3'd3; thr_hi_in = 3'd3;
    cycle();
    check("cfg_bad_set", 32'(cfg_bad), 32'd1);
    init = 1'b0;
    cycle();
    check("to_idle", 32'(state), 32'd2);
    // run/idle with a broken run
    set_in(1'b0, 4'b1110, 4'h0, 4'h0); cycle();
    check("to_active", 32'(active), 32'd1);
    fifo_empty = 4'hf; cycle(); cycle();
    fifo_empty = 4'b1011; cycle();
    fifo_empty = 4'hf; cycle(); cycle(); cycle();
    check("not_idle_yet", 32'(idle), 32'd0);
    cycle();
    check("idle_after_4", 32'(idle), 32'd1);
    // overflow accumulation
    set_in(1'b0, 4'b1110, 4'h0, 4'h0); cycle();
    set_in(1'b0, 4'b1110, 4'b1000, 4'b1000); cycle();
    check("ovf_err_vec", 32'(err_vec), 32'h8);
    set_in(1'b0, 4'b1110, 4'h0, 4'h0); cycle();
    set_in(1'b0, 4'b1110, 4'b0100, 4'b0100); cycle();
    check("ovf_accum", 32'(err_vec), 32'hc);
    // recover, then overflow and init together
    thr_lo_in = 3'd1; thr_hi_in = 3'd4;
    set_in(1'b1, 4'hf, 4'h0, 4'h0); cycle();
    set_in(1'b0, 4'hf, 4'h0, 4'h0); cycle();
    set_in(1'b0, 4'b0111, 4'h0, 4'h0); cycle();
    set_in(1'b1, 4'b0111, 4'b0001, 4'b0001); cycle();
    check("prio_error", 32'(error), 32'd1);
    set_in(1'b1, 4'hf, 4'h0, 4'h0); cycle();
    check("err_clear", 32'(err_vec), 32'h0);
    // reconfigure from ACTIVE
    set_in(1'b0, 4'hf, 4'h0, 4'h0); cycle();
    set_in(1'b0, 4'b1101, 4'h0, 4'h0); cycle();
    thr_lo_in = 3'd0; thr_hi_in = 3'd7;
    set_in(1'b1, 4'b1101, 4'h0, 4'h0); cycle();
    check("reconf_active0", 32'(active), 32'd0);
    cycle();
    init = 1'b0; cycle();
    check("reconf_hi", 32'(thr_hi), 32'd7);
    // mid-run async reset restores defaults without a clock edge
    set_in(1'b0, 4'b1101, 4'h0, 4'h0); cycle();
    @(negedge clk);
    do_reset();
    cycle();
    check("post_reset_init", 32'(state), 32'd1);
    // randomized run
    for (int n = 0; n < 600; n++) begin
      init       = ($urandom_range(0, 99) < 5);
      thr_lo_in  = 3'($urandom_range(0, 7));
      thr_hi_in  = 3'($urandom_range(0, 7));
      fifo_empty = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hf;
      fifo_full  = 4'($urandom);
      fifo_push  = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'h0;
      if (n % 200 == 199) do_reset();
      else cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
